// File: rtl/ebike_pkg.sv
// Shared eBike definitions: telemetry packet headers, the telemetry FSM
// state type and the byte-order mux used to build each packet.
package ebike_pkg;

    // Two fixed header bytes that open every telemetry packet
    localparam logic [7:0] TELEM_HDR0 = 8'hAA;
    localparam logic [7:0] TELEM_HDR1 = 8'h55;

    // Index of the final byte of a packet (8 bytes, 0..7)
    localparam logic [2:0] TELEM_LAST_IDX = 3'd7;

    // UART frame: start bit, 8 data bits, stop bit -> bit indices 0..9
    localparam logic [3:0] UART_LAST_BIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } telem_state_t;

    // Byte idx of a packet built from the three snapshot values.
    // Each 12-bit value goes out as high nibble (zero-padded) then low byte.
    function automatic logic [7:0] telemByte(input logic [2:0]  idx,
                                             input logic [11:0] battV,
                                             input logic [11:0] currAvg,
                                             input logic [11:0] torqueAvg);
        logic [7:0] b;
        b = TELEM_HDR0;
        case (idx)
            3'd0:    b = TELEM_HDR0;
            3'd1:    b = TELEM_HDR1;
            3'd2:    b = {4'h0, battV[11:8]};
            3'd3:    b = battV[7:0];
            3'd4:    b = {4'h0, currAvg[11:8]};
            3'd5:    b = currAvg[7:0];
            3'd6:    b = {4'h0, torqueAvg[11:8]};
            default: b = torqueAvg[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/UART_tx.sv
// 8N1 UART transmitter. A one-cycle trmt pulse loads a 10-bit frame
// (start, 8 data bits LSB first, stop) which is shifted out with each bit
// held for BAUD_DIV clocks. tx_done is asserted during the final clock of
// the stop bit so the next byte can be loaded with only one cycle of gap.
module UART_tx
    import ebike_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);

    logic        r_active;
    logic [9:0]  r_shift;
    logic [12:0] r_baudCnt;
    logic [3:0]  r_bitCnt;

    logic w_baudDone;
    logic w_lastBit;

    assign w_baudDone = (r_baudCnt == BAUD_LAST);
    assign w_lastBit  = (r_bitCnt == UART_LAST_BIT);

    // Frame load, baud timing and shifting; shift reg idles at all ones so TX idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_shift   <= 10'h3FF;
            r_baudCnt <= 13'd0;
            r_bitCnt  <= 4'd0;
        end else if (trmt) begin
            r_active  <= 1'b1;
            r_shift   <= {1'b1, tx_data, 1'b0};
            r_baudCnt <= 13'd0;
            r_bitCnt  <= 4'd0;
        end else if (r_active) begin
            if (w_baudDone) begin
                r_baudCnt <= 13'd0;
                if (w_lastBit) begin
                    r_active <= 1'b0;
                    r_shift  <= 10'h3FF;
                    r_bitCnt <= 4'd0;
                end else begin
                    r_shift  <= {1'b1, r_shift[9:1]};
                    r_bitCnt <= r_bitCnt + 4'd1;
                end
            end else begin
                r_baudCnt <= r_baudCnt + 13'd1;
            end
        end
    end

    assign TX      = r_shift[0];
    assign tx_done = r_active & w_baudDone & w_lastBit;

endmodule

// File: rtl/telemetry.sv
// Periodic telemetry source. Once per 2**PERIOD_BITS clocks it snapshots
// battery voltage, average current and average torque and sends them as an
// 8-byte packet over UART_tx. Ticks that arrive while a packet is still in
// flight are dropped rather than queued.
module telemetry
    import ebike_pkg::*;
#(
    parameter int PERIOD_BITS = 20,
    parameter int BAUD_DIV    = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] batt_v,
    input  logic [11:0] avg_curr,
    input  logic [11:0] avg_torque,
    output logic        TX,
    output logic        busy
);

    logic [PERIOD_BITS-1:0] r_periodCnt;
    logic [11:0]            r_battV;
    logic [11:0]            r_currAvg;
    logic [11:0]            r_torqueAvg;
    telem_state_t           r_state;
    logic [2:0]             r_idx;
    logic                   r_trmt;
    logic [7:0]             r_txData;
    logic                   r_busy;

    logic       w_tick;
    logic       w_snap;
    logic       w_txDone;
    logic [2:0] w_nextIdx;

    assign w_tick    = &r_periodCnt;
    assign w_snap    = (r_state == IDLE) && w_tick;
    assign w_nextIdx = r_idx + 3'd1;

    // Free-running period counter; wraps so ticks stay evenly spaced regardless of traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_periodCnt <= '0;
        end else begin
            r_periodCnt <= r_periodCnt + PERIOD_BITS'(1);
        end
    end

    // Capture all three inputs together when a packet is launched, freezing its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_battV     <= 12'd0;
            r_currAvg   <= 12'd0;
            r_torqueAvg <= 12'd0;
        end else if (w_snap) begin
            r_battV     <= batt_v;
            r_currAvg   <= avg_curr;
            r_torqueAvg <= avg_torque;
        end
    end

    // Packet sequencer: launch on tick, hand one byte at a time to the UART, wait for each to finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= 3'd0;
            r_trmt   <= 1'b0;
            r_txData <= 8'd0;
            r_busy   <= 1'b0;
        end else begin
            r_trmt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state  <= LOAD;
                        r_idx    <= 3'd0;
                        r_txData <= TELEM_HDR0;
                        r_trmt   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_txDone) begin
                        if (r_idx == TELEM_LAST_IDX) begin
                            r_state <= IDLE;
                            r_idx   <= 3'd0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= LOAD;
                            r_idx    <= w_nextIdx;
                            r_txData <= telemByte(w_nextIdx, r_battV, r_currAvg, r_torqueAvg);
                            r_trmt   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    UART_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (r_trmt),
        .tx_data (r_txData),
        .TX      (TX),
        .tx_done (w_txDone)
    );

endmodule
